// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU.
//   alu_op_e      : 4-bit operation encoding on the alu_mc op port
//   state_e       : control FSM states of alu_mc
//   is_multicycle : true for ops served by the iterative mul/div engine
package alu_pkg;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    AND   = 4'd2,
    OR    = 4'd3,
    XOR   = 4'd4,
    SLL   = 4'd5,
    SRL   = 4'd6,
    SRA   = 4'd7,
    SLT   = 4'd8,
    SLTU  = 4'd9,
    MUL   = 4'd10,
    MULHU = 4'd11,
    DIVU  = 4'd12,
    REMU  = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic logic is_multicycle(alu_op_e op);
    return op inside {MUL, MULHU, DIVU, REMU};
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / restoring divide engine, one bit per cycle.
//   clk, rst : clock, synchronous active-high reset
//   start    : load operands and begin WIDTH iterations
//   mode     : 0 = multiply (a*b), 1 = divide (a/b)
//   a, b     : operands captured on start
//   lo, hi   : register contents after the step taken this cycle
//              (mul: low/high product half, div: quotient/remainder)
//   done     : the step taken this cycle is the last one
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_q, lo_q, opnd;
  logic             mode_q;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic             take;

  // Post-step values are exported so the caller can register the final
  // result on the same edge as the last step.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd} : '0);
    div_sh  = {hi_q, lo_q[WIDTH-1]};
    // Unsigned compare (not a borrow bit) so a zero divisor always subtracts,
    // giving an all-ones quotient and remainder == dividend.
    take    = (div_sh >= {1'b0, opnd});
    if (!mode_q) begin
      {hi, lo} = {mul_sum, lo_q[WIDTH-1:1]};
    end else begin
      hi = take ? WIDTH'(div_sh - {1'b0, opnd}) : div_sh[WIDTH-1:0];
      lo = {lo_q[WIDTH-2:0], take};
    end
  end

  assign done = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd   <= '0;
      mode_q <= 1'b0;
    end else if (start) begin
      cnt    <= CNT_W'(WIDTH);
      hi_q   <= '0;
      lo_q   <= mode ? a : b;
      opnd   <= mode ? b : a;
      mode_q <= mode;
    end else if (cnt != '0) begin
      cnt  <= cnt - CNT_W'(1);
      hi_q <= hi;
      lo_q <= lo;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU with valid/ready handshakes on input and output.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake (ready only in IDLE)
//   op, a, b             : operation (alu_op_e encoding) and operands
//   out_valid / out_ready: output handshake (valid only in DONE)
//   result               : registered operation result
//   eq                   : a == b for the accepted operands
//   zero                 : result == 0
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             eq,
  output logic             zero
);

  localparam int SH_W = $clog2(WIDTH);

  state_e           state, state_n;
  alu_op_e          op_in, op_q;
  logic             hs, mc_in, eng_done;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] alu_res, eng_lo, eng_hi, eng_res;

  assign op_in     = alu_op_e'(op);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign hs        = in_valid && in_ready;
  assign mc_in     = is_multicycle(op_in);
  assign shamt     = b[SH_W-1:0];
  assign eng_res   = (op_q == MULHU || op_q == REMU) ? eng_hi : eng_lo;

  // Single-cycle datapath; undefined encodings fall through to ADD.
  always_comb begin
    alu_res = a + b;
    case (op_in)
      SUB:     alu_res = a + ~b + WIDTH'(1);
      AND:     alu_res = a & b;
      OR:      alu_res = a | b;
      XOR:     alu_res = a ^ b;
      SLL:     alu_res = a << shamt;
      SRL:     alu_res = a >> shamt;
      SRA:     alu_res = $signed(a) >>> shamt;
      SLT:     alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      SLTU:    alu_res = {{(WIDTH-1){1'b0}}, a < b};
      default: alu_res = a + b;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (hs && mc_in),
    .mode  (op_in == DIVU || op_in == REMU),
    .a     (a),
    .b     (b),
    .lo    (eng_lo),
    .hi    (eng_hi),
    .done  (eng_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (hs) state_n = mc_in ? BUSY : DONE;
      BUSY:    if (eng_done) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      eq     <= 1'b0;
      zero   <= 1'b0;
      op_q   <= ADD;
    end else if (hs) begin
      eq   <= (a == b);
      op_q <= op_in;
      if (!mc_in) begin
        result <= alu_res;
        zero   <= (alu_res == '0);
      end
    end else if (state == BUSY && eng_done) begin
      result <= eng_res;
      zero   <= (eng_res == '0);
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, out_valid, out_ready, eq, zero;
  logic [3:0]       op;
  logic [WIDTH-1:0] a, b, result;

  typedef struct {
    logic [31:0] res;
    logic        eq;
    int          lat;
  } exp_t;

  typedef struct {
    logic [3:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .eq        (eq),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Independent reference built on wide multiply and native / %.
  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    logic [4:0]  s;
    p = {32'b0, x} * {32'b0, y};
    s = y[4:0];
    case (o)
      4'd1:    return x - y;
      4'd2:    return x & y;
      4'd3:    return x | y;
      4'd4:    return x ^ y;
      4'd5:    return x << s;
      4'd6:    return x >> s;
      4'd7:    return $unsigned($signed(x) >>> s);
      4'd8:    return {31'b0, $signed(x) < $signed(y)};
      4'd9:    return {31'b0, x < y};
      4'd10:   return p[31:0];
      4'd11:   return p[63:32];
      4'd12:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'd13:   return (y == 0) ? x : x % y;
      default: return x + y;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake one op (caller guarantees IDLE) and record its expectation.
  // in_valid stays high with scrambled operands so BUSY/DONE must ignore it.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] r);
    exp_t e;
    e.res = r;
    e.eq  = (x == y);
    e.lat = (o >= 4'd10 && o <= 4'd13) ? WIDTH + 1 : 1;
    sb.push_back(e);
    op = o; a = x; b = y; in_valid = 1'b1;
    step();
    op = 4'($urandom); a = $urandom; b = $urandom;
  endtask

  // Cycles from the handshake edge until out_valid, bounded.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    step();
    step();
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (result !== '0)      begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_checks++; if (eq !== 1'b0)        begin n_fail++; $display("FAIL reset_eq: got %b want 0", eq); end
    n_checks++; if (zero !== 1'b0)      begin n_fail++; $display("FAIL reset_zero: got %b want 0", zero); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_cycle();
    vec_t v[$];
    exp_t e;
    int   lat;
    v.push_back('{4'd0,  32'h7FFF_FFFF, 32'h1,          32'h8000_0000});
    v.push_back('{4'd1,  32'h1234,      32'h1234,       32'h0});
    v.push_back('{4'd7,  32'h8000_0000, 32'h24,         32'hF800_0000});
    v.push_back('{4'd1,  32'h0,         32'h1,          32'hFFFF_FFFF});
    v.push_back('{4'd2,  32'hF0F0_1234, 32'h0FF0_FF00,  32'h00F0_1200});
    v.push_back('{4'd3,  32'hF000_0001, 32'h0000_0100,  32'hF000_0101});
    v.push_back('{4'd4,  32'hAAAA_5555, 32'hFFFF_0000,  32'h5555_5555});
    v.push_back('{4'd5,  32'h1,         32'h21,         32'h2});
    v.push_back('{4'd6,  32'h8000_0000, 32'h3F,         32'h1});
    v.push_back('{4'd8,  32'hFFFF_FFFF, 32'h1,          32'h1});
    v.push_back('{4'd9,  32'hFFFF_FFFF, 32'h1,          32'h0});
    v.push_back('{4'd14, 32'h3,         32'h4,          32'h7});
    v.push_back('{4'd15, 32'hFFFF_FFFF, 32'h1,          32'h0});
    foreach (v[i]) begin
      issue(v[i].o, v[i].x, v[i].y, v[i].r);
      wait_out(lat);
      e = sb.pop_front();
      n_checks++; if (lat != e.lat)           begin n_fail++; $display("FAIL single[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      n_checks++; if (result !== e.res)       begin n_fail++; $display("FAIL single[%0d] result: got %h want %h", i, result, e.res); end
      n_checks++; if (eq !== e.eq)            begin n_fail++; $display("FAIL single[%0d] eq: got %b want %b", i, eq, e.eq); end
      n_checks++; if (zero !== (e.res == 0))  begin n_fail++; $display("FAIL single[%0d] zero: got %b want %b", i, zero, e.res == 0); end
      step();
      n_checks++; if (in_ready !== 1'b1)      begin n_fail++; $display("FAIL single[%0d] back_to_idle: got %b want 1", i, in_ready); end
    end
  endtask

  task automatic test_multi_cycle();
    vec_t v[$];
    exp_t e;
    int   lat;
    v.push_back('{4'd10, 32'hFFFF_FFFF, 32'h2,          32'hFFFF_FFFE});
    v.push_back('{4'd11, 32'hFFFF_FFFF, 32'h2,          32'h1});
    v.push_back('{4'd12, 32'd100,       32'd7,          32'd14});
    v.push_back('{4'd13, 32'd100,       32'd7,          32'd2});
    v.push_back('{4'd12, 32'd100,       32'd0,          32'hFFFF_FFFF});
    v.push_back('{4'd13, 32'd100,       32'd0,          32'd100});
    v.push_back('{4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE});
    v.push_back('{4'd10, 32'h1234_5678, 32'h0,          32'h0});
    v.push_back('{4'd13, 32'h8000_0001, 32'h8000_0001,  32'h0});
    foreach (v[i]) begin
      issue(v[i].o, v[i].x, v[i].y, v[i].r);
      wait_out(lat);
      e = sb.pop_front();
      n_checks++; if (lat != e.lat)           begin n_fail++; $display("FAIL multi[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      n_checks++; if (result !== e.res)       begin n_fail++; $display("FAIL multi[%0d] result: got %h want %h", i, result, e.res); end
      n_checks++; if (eq !== e.eq)            begin n_fail++; $display("FAIL multi[%0d] eq: got %b want %b", i, eq, e.eq); end
      n_checks++; if (zero !== (e.res == 0))  begin n_fail++; $display("FAIL multi[%0d] zero: got %b want %b", i, zero, e.res == 0); end
      step();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    out_ready = 1'b0;
    issue(4'd11, 32'h8000_0000, 32'h6, 32'h3);
    wait_out(lat);
    e = sb.pop_front();
    n_checks++; if (lat != e.lat)     begin n_fail++; $display("FAIL bp latency: got %0d want %0d", lat, e.lat); end
    n_checks++; if (result !== e.res) begin n_fail++; $display("FAIL bp result: got %h want %h", result, e.res); end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; op = 4'd0; a = $urandom; b = $urandom;
      step();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp hold_valid[%0d]: got %b want 1", c, out_valid); end
      n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp in_ready[%0d]: got %b want 0", c, in_ready); end
      n_checks++; if (result !== e.res)   begin n_fail++; $display("FAIL bp hold_result[%0d]: got %h want %h", c, result, e.res); end
      n_checks++; if (eq !== 1'b0 || zero !== 1'b0) begin n_fail++; $display("FAIL bp hold_flags[%0d]: got eq=%b zero=%b want 0 0", c, eq, zero); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp release_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp release_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    int   lat;
    int   seen;
    issue(4'd12, 32'd1000, 32'd3, 32'd333);
    // First BUSY cycle is now in progress; advance to the tenth.
    for (int c = 0; c < 9; c++) step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    void'(sb.pop_back());
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL abort in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort out_valid: got %b want 0", out_valid); end
    n_checks++; if (result !== '0)      begin n_fail++; $display("FAIL abort result: got %h want 0", result); end
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (out_valid) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL abort stray_output: got %0d valid cycles want 0", seen); end
    issue(4'd0, 32'd3, 32'd4, 32'd7);
    wait_out(lat);
    e = sb.pop_front();
    n_checks++; if (lat != e.lat)     begin n_fail++; $display("FAIL abort_add latency: got %0d want %0d", lat, e.lat); end
    n_checks++; if (result !== e.res) begin n_fail++; $display("FAIL abort_add result: got %h want %h", result, e.res); end
    step();
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          lat;
    logic [3:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 24; i++) begin
      o = 4'($urandom_range(0, 15));
      x = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      y = (i % 3 == 1) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 7 == 0) y = 32'h0;
      if (i % 5 == 0) y = x;
      issue(o, x, y, model(o, x, y));
      wait_out(lat);
      e = sb.pop_front();
      n_checks++; if (lat != e.lat)          begin n_fail++; $display("FAIL b2b[%0d] op=%0d latency: got %0d want %0d", i, o, lat, e.lat); end
      n_checks++; if (result !== e.res)      begin n_fail++; $display("FAIL b2b[%0d] op=%0d a=%h b=%h result: got %h want %h", i, o, x, y, result, e.res); end
      n_checks++; if (eq !== e.eq)           begin n_fail++; $display("FAIL b2b[%0d] eq: got %b want %b", i, eq, e.eq); end
      n_checks++; if (zero !== (e.res == 0)) begin n_fail++; $display("FAIL b2b[%0d] zero: got %b want %b", i, zero, e.res == 0); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_multi_cycle();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
